// File: rtl/clock_set_ctrl_pkg.sv
// clock_pkg: shared states, field encodings, BCD packing offsets and the mm/ss increment helper.
package clock_pkg;
   typedef enum logic [1:0] {RUN, SET_MIN, SET_SEC} state_e;
   localparam logic [1:0] EF_NONE = 2'b00;
   localparam logic [1:0] EF_MIN = 2'b01;
   localparam logic [1:0] EF_SEC = 2'b10;
   localparam int MIN_LSB = 8;
   localparam int SEC_LSB = 0;
   // Illegal digits and 59 both collapse to 00.
   function automatic logic [7:0] bcd_inc59(input logic [3:0] tens, input logic [3:0] ones);
      return (tens > 4'd5 || ones > 4'd9 || (tens == 4'd5 && ones == 4'd9)) ? 8'h00 :
             (ones == 4'd9) ? {tens + 4'd1, 4'd0} : {tens, ones + 4'd1};
   endfunction
endpackage

// File: rtl/clock_set_ctrl_if.sv
// clock_set_ctrl_if: buttons and time bus between the panel, the set controller and the clock counter.
interface clock_set_ctrl_if;
   logic btn_mode;
   logic btn_inc;
   logic [15:0] cur_time;
   logic hold;
   logic load;
   logic [15:0] load_time;
   logic [1:0] edit_field;
   modport master (output btn_mode, btn_inc, cur_time, input hold, load, load_time, edit_field);
   modport slave (input btn_mode, btn_inc, cur_time, output hold, load, load_time, edit_field);
endinterface

// File: rtl/clock_set_ctrl_debounce.sv
// btn_debounce: 2-FF synchroniser, debounce counter and registered press pulse on the debounced rising edge.
module btn_debounce #(
   parameter int DB_CYCLES = 40
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic level_o,
   output logic press_o
);
   localparam int CW = $clog2(DB_CYCLES + 1);
   logic [1:0] sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic level_q, level_d, prev_q, press_q, differ, done;
   always_comb begin
      differ = sync_q[1] != level_q;
      done = differ && cnt_q == CW'(DB_CYCLES - 1);
      cnt_d = (!differ || done) ? '0 : cnt_q + CW'(1);
      level_d = done ? sync_q[1] : level_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         cnt_q <= '0;
         level_q <= 1'b0;
         prev_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn_i};
         cnt_q <= cnt_d;
         level_q <= level_d;
         prev_q <= level_q;
         press_q <= level_q & ~prev_q;
      end
   end
   assign level_o = level_q;
   assign press_o = press_q;
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: debounced MODE/INC front end, INC auto-repeat and the mm:ss edit state machine.
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter int FREQ = 2_000,
   parameter int DEBOUNCE_MS = 20,
   parameter int RPT_MS = 250
) (
   input logic clk,
   input logic rst,
   clock_set_ctrl_if.slave bus
);
   localparam int DB_CYCLES = FREQ * DEBOUNCE_MS / 1000;
   localparam int RPT_CYCLES = FREQ * RPT_MS / 1000;
   localparam int RW = $clog2(2 * RPT_CYCLES + 1);
   logic mode_press, inc_press, inc_lvl, rpt_fire, inc_ev;
   logic first_q, first_d, load_q, load_d;
   logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
   logic [15:0] edit_q, edit_d, load_time_q, load_time_d;
   state_e state_q, state_d;
   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_mode (.clk(clk), .rst(rst), .btn_i(bus.btn_mode), .level_o(), .press_o(mode_press));
   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_inc (.clk(clk), .rst(rst), .btn_i(bus.btn_inc), .level_o(inc_lvl), .press_o(inc_press));
   // Repeat counter restarts at 1 on each press/repeat so it equals cycles elapsed since that event.
   always_comb begin
      rpt_fire = inc_lvl && rpt_cnt_q == (first_q ? RW'(2 * RPT_CYCLES) : RW'(RPT_CYCLES));
      rpt_cnt_d = !inc_lvl ? '0 : (inc_press || rpt_fire) ? RW'(1) : rpt_cnt_q + RW'(1);
      first_d = inc_press ? 1'b1 : rpt_fire ? 1'b0 : first_q;
      inc_ev = inc_press | rpt_fire;
   end
   always_comb begin
      state_d = state_q;
      edit_d = edit_q;
      load_d = 1'b0;
      load_time_d = load_time_q;
      if (mode_press) begin
         unique case (state_q)
            RUN: begin
               state_d = SET_MIN;
               edit_d = bus.cur_time;
            end
            SET_MIN: state_d = SET_SEC;
            default: begin
               state_d = RUN;
               load_d = 1'b1;
               load_time_d = edit_q;
            end
         endcase
      end else if (inc_ev && state_q == SET_MIN) begin
         edit_d[MIN_LSB+:8] = bcd_inc59(edit_q[MIN_LSB+4+:4], edit_q[MIN_LSB+:4]);
      end else if (inc_ev && state_q == SET_SEC) begin
         edit_d[SEC_LSB+:8] = bcd_inc59(edit_q[SEC_LSB+4+:4], edit_q[SEC_LSB+:4]);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         edit_q <= '0;
         load_q <= 1'b0;
         load_time_q <= '0;
         rpt_cnt_q <= '0;
         first_q <= 1'b1;
      end else begin
         state_q <= state_d;
         edit_q <= edit_d;
         load_q <= load_d;
         load_time_q <= load_time_d;
         rpt_cnt_q <= rpt_cnt_d;
         first_q <= first_d;
      end
   end
   assign bus.hold = state_q != RUN;
   assign bus.load = load_q;
   assign bus.load_time = load_time_q;
   assign bus.edit_field = (state_q == SET_MIN) ? EF_MIN : (state_q == SET_SEC) ? EF_SEC : EF_NONE;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: scoreboard bench; expected load values are queued as edits are driven and popped on load.
module tb_clock_set_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;
   int loads = 0;
   int n;
   logic [15:0] sb_q[$];
   always #5 clk = ~clk;
   clock_set_ctrl_if bus();
   clock_set_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick(input int c = 1);
      repeat (c) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic press(input logic m, input logic i);
      bus.btn_mode = m;
      bus.btn_inc = i;
      tick(50);
      bus.btn_mode = 1'b0;
      bus.btn_inc = 1'b0;
      tick(50);
   endtask
   task automatic close_edit(input logic [15:0] exp);
      sb_q.push_back(exp);
      press(1'b1, 1'b0);
      check("close_hold", bus.hold, 0);
      check("close_field", bus.edit_field, 2'b00);
      check("close_load_time", bus.load_time, exp);
   endtask
   task automatic edit(input logic [15:0] t, input logic to_sec, input int incs, input logic [15:0] exp);
      bus.cur_time = t;
      press(1'b1, 1'b0);
      if (to_sec) press(1'b1, 1'b0);
      repeat (incs) press(1'b0, 1'b1);
      if (!to_sec) press(1'b1, 1'b0);
      close_edit(exp);
   endtask
   always @(negedge clk) begin
      if (bus.load) begin
         loads++;
         check("hold_at_load", bus.hold, 0);
         check("sb_has_entry", sb_q.size() != 0, 1);
         if (sb_q.size() != 0) check("load_time", bus.load_time, sb_q.pop_front());
      end
   end
   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
   initial begin
      bus.btn_mode = 1'b0;
      bus.btn_inc = 1'b0;
      bus.cur_time = 16'h5930;
      tick(3);
      check("rst_hold", bus.hold, 0);
      check("rst_load", bus.load, 0);
      check("rst_load_time", bus.load_time, 16'h0000);
      check("rst_field", bus.edit_field, 2'b00);
      rst = 1'b0;
      tick(5);
      for (int k = 0; k < 12; k++) begin
         bus.btn_mode = ~bus.btn_mode;
         tick(5);
      end
      bus.btn_mode = 1'b1;
      n = 0;
      while (!bus.hold && n < 200) begin
         tick();
         n++;
      end
      check("bounce_latency", n, 44);
      tick(100);
      check("bounce_field", bus.edit_field, 2'b01);
      check("bounce_hold", bus.hold, 1);
      bus.btn_mode = 1'b0;
      tick(60);
      press(1'b0, 1'b1);
      press(1'b1, 1'b0);
      check("to_sec_field", bus.edit_field, 2'b10);
      close_edit(16'h0030);
      check("load_count_1", loads, 1);
      tick(20);
      check("load_time_held", bus.load_time, 16'h0030);
      check("load_low", bus.load, 0);
      edit(16'h1209, 1'b1, 1, 16'h1210);
      edit(16'h1259, 1'b1, 1, 16'h1200);
      edit(16'h0945, 1'b0, 1, 16'h1045);
      edit(16'h7A3C, 1'b0, 1, 16'h003C);
      edit(16'h5959, 1'b1, 2, 16'h5901);
      check("load_count_6", loads, 6);
      bus.cur_time = 16'h2000;
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      bus.btn_inc = 1'b1;
      tick(2000);
      bus.btn_inc = 1'b0;
      tick(2000);
      n = 1;
      for (int c = 43 + 1000; c <= 2000 + 41; c += 500) n++;
      close_edit(16'h2000 | 16'(n));
      bus.cur_time = 16'h3415;
      press(1'b1, 1'b0);
      press(1'b1, 1'b1);
      check("simul_field", bus.edit_field, 2'b10);
      close_edit(16'h3415);
      check("load_count_8", loads, 8);
      bus.cur_time = 16'h1244;
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_hold", bus.hold, 0);
      check("midrst_field", bus.edit_field, 2'b00);
      check("midrst_load_time", bus.load_time, 16'h0000);
      check("midrst_load", bus.load, 0);
      tick(200);
      check("midrst_no_load", loads, 8);
      press(1'b1, 1'b0);
      check("after_rst_field", bus.edit_field, 2'b01);
      press(1'b1, 1'b0);
      close_edit(16'h1244);
      check("load_count_9", loads, 9);
      check("sb_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
